// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - CPU load/store to shared-bus master with lane steering and wait states
// Bus outputs are decoded from state so a reset edge releases the bus immediately.
module io_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1,
  parameter int DEV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              BC,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        ctrl,
  inout  wire  [DATA_W-1:0] data
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE, S_ERR} state_t;
  localparam int CNT_W = 8;

  state_t            r_state, w_next;
  logic              r_we, r_sext;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_misaligned, w_is_dev, w_bus_active;
  logic [DATA_W-1:0] w_store, w_shifted, w_load;

  assign w_misaligned = (cpu_size == 2'b11) ||
                        (cpu_size == 2'b01 && cpu_addr[0]) ||
                        (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
  assign w_is_dev     = (r_addr[ADDR_W-1 -: 20] == 20'hFFFFF);
  assign w_bus_active = (r_state == S_ADDR) || (r_state == S_WAIT) || (r_state == S_DONE);

  // Store data is steered onto its byte lanes once, at acceptance.
  always_comb begin
    w_store = cpu_wdata;
    case (cpu_size)
      2'b00:   w_store = DATA_W'(cpu_wdata[7:0]) << {cpu_addr[1:0], 3'b000};
      2'b01:   w_store = DATA_W'(cpu_wdata[15:0]) << {cpu_addr[1], 4'b0000};
      default: w_store = cpu_wdata;
    endcase
  end

  // Aligned accesses make one byte-granular shift serve byte, half and word loads.
  assign w_shifted = data >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_size)
      2'b00:   w_load = {{(DATA_W-8){r_sext & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{(DATA_W-16){r_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req) w_next = w_misaligned ? S_ERR : S_ADDR;
      S_ADDR:  w_next = S_WAIT;
      S_WAIT:  if (r_cnt <= CNT_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && cpu_req) begin
        r_we    <= cpu_we;
        r_sext  <= cpu_sext;
        r_size  <= cpu_size;
        r_addr  <= cpu_addr;
        r_wdata <= w_store;
      end
      case (r_state)
        S_ADDR:  r_cnt <= w_is_dev ? CNT_W'(DEV_LAT) : CNT_W'(RAM_LAT);
        S_WAIT:  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        S_DONE:  if (!r_we) r_rdata <= w_load;
        default: ;
      endcase
    end
  end

  assign BC        = w_bus_active;
  assign addr      = w_bus_active ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign ctrl      = w_bus_active ? {r_size, r_we, ~r_we} : 4'b0000;
  assign data      = (w_bus_active && r_we) ? r_wdata : 'z;
  assign cpu_ack   = (r_state == S_DONE);
  assign cpu_err   = (r_state == S_ERR);
  // The live load value is forwarded during DONE so it is valid with cpu_ack.
  assign cpu_rdata = (r_state == S_DONE && !r_we) ? w_load : r_rdata;

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - directed self-checking bench for io_bus_master
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_sext = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  wire  [31:0] cpu_rdata;
  wire         cpu_ack, cpu_err, BC;
  wire  [31:0] addr;
  wire  [3:0]  ctrl;
  wire  [31:0] data;

  logic        tb_oe = 1'b0;
  logic [31:0] tb_data = '0;
  localparam logic [31:0] PROBE = 32'h5A5A_A5A5;
  assign data = tb_oe ? tb_data : 'z;

  io_bus_master #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .DEV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_sext(cpu_sext), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .BC(BC), .addr(addr), .ctrl(ctrl), .data(data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int          n_bc, n_ack, n_err, n_both;
  logic [31:0] s_rdata, s_addr, s_data;
  logic [3:0]  s_ctrl;
  logic        stable, ack_in_bc;

  // Issues one request from IDLE and observes 20 cycles; caller is #1 after a posedge.
  task automatic do_xfer(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bd);
    logic first;
    cpu_we = we; cpu_size = size; cpu_sext = sext; cpu_addr = a; cpu_wdata = wd;
    tb_oe = ~we; tb_data = bd; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n_bc = 0; n_ack = 0; n_err = 0; n_both = 0; stable = 1'b1; ack_in_bc = 1'b0; first = 1'b1;
    s_rdata = '0; s_addr = '0; s_data = '0; s_ctrl = '0;
    for (int i = 0; i < 20; i++) begin
      if (BC) begin
        n_bc++;
        if (first) begin
          s_ctrl = ctrl; s_addr = addr; s_data = data; first = 1'b0;
        end else if (ctrl !== s_ctrl || addr !== s_addr || data !== s_data) begin
          stable = 1'b0;
        end
      end
      if (cpu_ack) begin n_ack++; s_rdata = cpu_rdata; ack_in_bc = BC; end
      if (cpu_err) n_err++;
      if (cpu_ack && cpu_err) n_both++;
      @(posedge clk); #1;
    end
    tb_oe = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_size = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (BC !== 1'b0) begin n_fail++; $display("FAIL reset_bc got %b exp 0", BC); end
    n_chk++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", addr); end
    n_chk++; if (ctrl !== 4'h0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0000", ctrl); end
    n_chk++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", cpu_ack); end
    n_chk++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", cpu_err); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", cpu_rdata); end
    tb_oe = 1'b1; tb_data = PROBE; #1;
    n_chk++; if (data !== PROBE) begin n_fail++; $display("FAIL reset_data_released got %h exp %h", data, PROBE); end
    tb_oe = 1'b0; cpu_req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store;
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    n_chk++; if (n_bc !== 3) begin n_fail++; $display("FAIL wstore_bc_cycles got %0d exp 3", n_bc); end
    n_chk++; if (s_ctrl !== 4'b1010) begin n_fail++; $display("FAIL wstore_ctrl got %b exp 1010", s_ctrl); end
    n_chk++; if (s_addr !== 32'h10) begin n_fail++; $display("FAIL wstore_addr got %h exp 00000010", s_addr); end
    n_chk++; if (s_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wstore_data got %h exp deadbeef", s_data); end
    n_chk++; if (stable !== 1'b1) begin n_fail++; $display("FAIL wstore_stable got %b exp 1", stable); end
    n_chk++; if (n_ack !== 1 || ack_in_bc !== 1'b1) begin n_fail++; $display("FAIL wstore_ack got %0d/%b exp 1/1", n_ack, ack_in_bc); end
    n_chk++; if (n_err !== 0) begin n_fail++; $display("FAIL wstore_err got %0d exp 0", n_err); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL wstore_rdata_hold got %h exp 0", cpu_rdata); end
  endtask

  task automatic test_byte_load_sext;
    do_xfer(1'b0, 2'b00, 1'b1, 32'hFFFF_F061, 32'h0, 32'h0000_8000);
    n_chk++; if (n_bc !== 6) begin n_fail++; $display("FAIL bload_bc_cycles got %0d exp 6", n_bc); end
    n_chk++; if (s_addr !== 32'hFFFF_F060) begin n_fail++; $display("FAIL bload_addr got %h exp fffff060", s_addr); end
    n_chk++; if (s_ctrl !== 4'b0001) begin n_fail++; $display("FAIL bload_ctrl got %b exp 0001", s_ctrl); end
    n_chk++; if (n_ack !== 1) begin n_fail++; $display("FAIL bload_ack got %0d exp 1", n_ack); end
    n_chk++; if (s_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL bload_rdata got %h exp ffffff80", s_rdata); end
    n_chk++; if (cpu_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL bload_rdata_hold got %h exp ffffff80", cpu_rdata); end
  endtask

  task automatic test_half_store;
    do_xfer(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0);
    n_chk++; if (s_data !== 32'hABCD_0000) begin n_fail++; $display("FAIL hstore_data got %h exp abcd0000", s_data); end
    n_chk++; if (s_ctrl !== 4'b0110) begin n_fail++; $display("FAIL hstore_ctrl got %b exp 0110", s_ctrl); end
    n_chk++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL hstore_addr got %h exp 0", s_addr); end
    n_chk++; if (n_bc !== 3 || n_ack !== 1) begin n_fail++; $display("FAIL hstore_cycle got bc=%0d ack=%0d exp 3/1", n_bc, n_ack); end
  endtask

  task automatic test_lanes;
    do_xfer(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8765_4321);
    n_chk++; if (s_rdata !== 32'h0000_8765) begin n_fail++; $display("FAIL hload_zext got %h exp 00008765", s_rdata); end
    n_chk++; if (s_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL hload_addr got %h exp 00000100", s_addr); end
    do_xfer(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h8765_4321);
    n_chk++; if (s_rdata !== 32'h0000_4321) begin n_fail++; $display("FAIL hload_sext_pos got %h exp 00004321", s_rdata); end
    do_xfer(1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h5555_55AB, 32'h0);
    n_chk++; if (s_data !== 32'hAB00_0000) begin n_fail++; $display("FAIL bstore_data got %h exp ab000000", s_data); end
    n_chk++; if (s_ctrl !== 4'b0010) begin n_fail++; $display("FAIL bstore_ctrl got %b exp 0010", s_ctrl); end
    n_chk++; if (cpu_rdata !== 32'h0000_4321) begin n_fail++; $display("FAIL store_rdata_hold got %h exp 00004321", cpu_rdata); end
  endtask

  task automatic test_errors;
    do_xfer(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0);
    n_chk++; if (n_err !== 1) begin n_fail++; $display("FAIL err_word_misaligned got %0d exp 1", n_err); end
    n_chk++; if (n_bc !== 0 || n_ack !== 0) begin n_fail++; $display("FAIL err_no_bus got bc=%0d ack=%0d exp 0/0", n_bc, n_ack); end
    do_xfer(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0);
    n_chk++; if (n_err !== 1 || n_bc !== 0) begin n_fail++; $display("FAIL err_size11 got err=%0d bc=%0d exp 1/0", n_err, n_bc); end
    do_xfer(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 32'h0);
    n_chk++; if (n_err !== 1 || n_bc !== 0) begin n_fail++; $display("FAIL err_half_odd got err=%0d bc=%0d exp 1/0", n_err, n_bc); end
    n_chk++; if (cpu_rdata !== 32'h0000_4321) begin n_fail++; $display("FAIL err_rdata_hold got %h exp 00004321", cpu_rdata); end
    do_xfer(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D);
    n_chk++; if (n_ack !== 1 || n_err !== 0) begin n_fail++; $display("FAIL after_err_ack got ack=%0d err=%0d exp 1/0", n_ack, n_err); end
    n_chk++; if (s_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL after_err_rdata got %h exp cafef00d", s_rdata); end
    n_chk++; if (n_bc !== 3 || n_both !== 0) begin n_fail++; $display("FAIL after_err_bc got bc=%0d both=%0d exp 3/0", n_bc, n_both); end
  endtask

  task automatic test_reset_mid;
    int acks, bcs;
    cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'hFFFF_F004; cpu_wdata = 32'h1111_2222; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (BC !== 1'b1 || data !== 32'h1111_2222) begin n_fail++; $display("FAIL mid_pre_bus got bc=%b data=%h exp 1/11112222", BC, data); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (BC !== 1'b0) begin n_fail++; $display("FAIL mid_bc got %b exp 0", BC); end
    n_chk++; if (ctrl !== 4'h0 || addr !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl_addr got %b/%h exp 0000/0", ctrl, addr); end
    n_chk++; if (cpu_ack !== 1'b0 || cpu_err !== 1'b0) begin n_fail++; $display("FAIL mid_ack_err got %b/%b exp 0/0", cpu_ack, cpu_err); end
    tb_oe = 1'b1; tb_data = PROBE; #1;
    n_chk++; if (data !== PROBE) begin n_fail++; $display("FAIL mid_data_released got %h exp %h", data, PROBE); end
    tb_oe = 1'b0; rst_n = 1'b1;
    acks = 0; bcs = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cpu_ack || cpu_err) acks++;
      if (BC) bcs++;
    end
    n_chk++; if (acks !== 0 || bcs !== 0) begin n_fail++; $display("FAIL mid_aborted got resp=%0d bc=%0d exp 0/0", acks, bcs); end
  endtask

  task automatic test_back_to_back;
    int pulses, low_run, min_low;
    logic prev_bc;
    cpu_we = 1'b0; cpu_size = 2'b10; cpu_sext = 1'b0; cpu_addr = 32'h0000_0040;
    tb_oe = 1'b1; tb_data = 32'h0102_0304; cpu_req = 1'b1;
    n_ack = 0; n_both = 0; pulses = 0; low_run = 0; min_low = 99; prev_bc = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) n_ack++;
      if (cpu_ack && cpu_err) n_both++;
      if (BC && !prev_bc) begin
        pulses++;
        if (pulses > 1 && low_run < min_low) min_low = low_run;
      end
      if (!BC) low_run++;
      else low_run = 0;
      prev_bc = BC;
      if (i == 6) cpu_req = 1'b0;
    end
    tb_oe = 1'b0;
    n_chk++; if (n_ack !== 2) begin n_fail++; $display("FAIL b2b_acks got %0d exp 2", n_ack); end
    n_chk++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_bc_pulses got %0d exp 2", pulses); end
    n_chk++; if (min_low !== 1) begin n_fail++; $display("FAIL b2b_bc_gap got %0d exp 1", min_low); end
    n_chk++; if (n_both !== 0) begin n_fail++; $display("FAIL b2b_ack_err_overlap got %0d exp 0", n_both); end
    n_chk++; if (cpu_rdata !== 32'h0102_0304) begin n_fail++; $display("FAIL b2b_rdata got %h exp 01020304", cpu_rdata); end
  endtask

  initial begin
    test_reset;
    test_word_store;
    test_byte_load_sext;
    test_half_store;
    test_lanes;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
